// File: rtl/xillybus_stream_fifo.sv
// Parametrised Xillybus loopback/stream FIFO with EOF generation, fill level and sticky error flags.
// Optional peak-level tracking is enabled by defining XILLY_FIFO_PEAK_EN.
module xillybus_stream_fifo #(
  parameter int WIDTH        = 32,
  parameter int DEPTH        = 512,
  parameter int AFULL_THRESH = DEPTH - 4,
  parameter bit EOF_ON_CLOSE = 1'b1
) (
  input  logic                     bus_clk,
  input  logic                     srst,
  input  logic                     user_w_wren,
  input  logic [WIDTH-1:0]         user_w_data,
  input  logic                     user_w_open,
  output logic                     user_w_full,
  input  logic                     user_r_rden,
  output logic [WIDTH-1:0]         user_r_data,
  input  logic                     user_r_open,
  output logic                     user_r_empty,
  output logic                     user_r_eof,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     afull,
  output logic                     overflow,
  output logic                     underflow,
  output logic [$clog2(DEPTH):0]   peak_level
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int LVL_W  = ADDR_W + 1;

  logic [WIDTH-1:0]  mem [DEPTH];

  logic              irst;
  logic              wrAccept;
  logic              rdAccept;
  logic              wClose;

  logic [ADDR_W-1:0] wrPtr_q, wrPtr_d;
  logic [ADDR_W-1:0] rdPtr_q, rdPtr_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic              full_q, full_d;
  logic              empty_q, empty_d;
  logic              afull_q, afull_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;
  logic              eofPending_q, eofPending_d;
  logic              eof_q, eof_d;
  logic              wOpenPrev_q;
  logic [WIDTH-1:0]  rdData_q, rdData_d;

  // Closing both streams acts as a reset so every new session starts clean.
  assign irst = srst | (~user_w_open & ~user_r_open);

  always_comb begin
    wrAccept = user_w_wren & ~full_q;
    rdAccept = user_r_rden & ~empty_q;
    wClose   = wOpenPrev_q & ~user_w_open;

    wrPtr_d  = wrAccept ? wrPtr_q + ADDR_W'(1) : wrPtr_q;
    rdPtr_d  = rdAccept ? rdPtr_q + ADDR_W'(1) : rdPtr_q;
    rdData_d = rdAccept ? mem[rdPtr_q] : rdData_q;

    case ({wrAccept, rdAccept})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase

    // Flags come from the next level so they line up with the level register.
    full_d      = (level_d == LVL_W'(DEPTH));
    empty_d     = (level_d == '0);
    afull_d     = (level_d >= LVL_W'(AFULL_THRESH));
    overflow_d  = overflow_q | (user_w_wren & full_q);
    underflow_d = underflow_q | (user_r_rden & empty_q);

    eofPending_d = EOF_ON_CLOSE ? (eofPending_q | (wClose & user_r_open)) : 1'b0;
    eof_d        = eofPending_d & empty_d;
  end

  always_ff @(posedge bus_clk) begin
    if (irst) begin
      wrPtr_q      <= '0;
      rdPtr_q      <= '0;
      level_q      <= '0;
      full_q       <= 1'b0;
      empty_q      <= 1'b1;
      afull_q      <= 1'b0;
      overflow_q   <= 1'b0;
      underflow_q  <= 1'b0;
      eofPending_q <= 1'b0;
      eof_q        <= 1'b0;
      rdData_q     <= '0;
      wOpenPrev_q  <= user_w_open;
    end else begin
      wrPtr_q      <= wrPtr_d;
      rdPtr_q      <= rdPtr_d;
      level_q      <= level_d;
      full_q       <= full_d;
      empty_q      <= empty_d;
      afull_q      <= afull_d;
      overflow_q   <= overflow_d;
      underflow_q  <= underflow_d;
      eofPending_q <= eofPending_d;
      eof_q        <= eof_d;
      rdData_q     <= rdData_d;
      wOpenPrev_q  <= user_w_open;
    end
  end

  // Storage has no reset; stale words are unreachable once pointers clear.
  always_ff @(posedge bus_clk) begin
    if (wrAccept && !irst) begin
      mem[wrPtr_q] <= user_w_data;
    end
  end

  assign user_w_full  = full_q;
  assign user_r_empty = empty_q;
  assign user_r_data  = rdData_q;
  assign user_r_eof   = eof_q;
  assign level        = level_q;
  assign afull        = afull_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

`ifdef XILLY_FIFO_PEAK_EN
  logic [LVL_W-1:0] peak_q, peak_d;

  always_comb begin
    peak_d = (level_d > peak_q) ? level_d : peak_q;
  end

  always_ff @(posedge bus_clk) begin
    if (irst) begin
      peak_q <= '0;
    end else begin
      peak_q <= peak_d;
    end
  end

  assign peak_level = peak_q;
`else
  assign peak_level = '0;
`endif

endmodule
